regfile_wb_arbiter: RTL and testbench

Write-port controller for the 32x32 register file (single write port, two read ports, r0 hard-wired zero). Arbitrates two writeback requesters (ALU path, multdiv/load path) onto the one write port with round-robin fairness. Runs a software-triggered clear sweep that zeroes r1..r31 without global reset. All write-port outputs are registered and drive the regfile's ctrl_writeEn, ctrl_writeReg and data_writeReg directly.

---
 rtl/regfile_ctrl_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared widths, sweep bounds and FSM encoding for the regfile write-port
// controller (arbiter, sweep FSM, requester interface).
package regfile_ctrl_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // Sweep walks FIRST_IDX..LAST_IDX; r0 is hard-wired zero and skipped.
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Two writeback requesters (ALU path, multdiv/load path) into the write-port
// controller. master = requester side, slave = controller side.
interface regfile_wb_arbiter_if;
    import regfile_ctrl_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Ports: clock, ctrl_reset (async, active-low),
// valid0/valid1 requests, block (suppress all grants), gnt0/gnt1 grants.
module rr_arb2 (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic valid0,
    input  logic valid1,
    input  logic block,
    output logic gnt0,
    output logic gnt1
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
    logic prio;

    always_comb begin
        gnt0 = valid0 & ~block & (~valid1 | ~prio);
        gnt1 = valid1 & ~block & (~valid0 |  prio);
    end

    // The loser of the last grant gets the next tie.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            prio <= 1'b0;
        end else if (gnt0) begin
            prio <= 1'b1;
        end else if (gnt1) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port controller: round-robin writeback arbitration plus a
// zeroing sweep of r1..r31.
// Ports: clock, ctrl_reset (async, active-low), req (requester interface,
// slave side), clear_req/clear_busy/clear_done (sweep control),
// ctrl_writeEn/ctrl_writeReg/data_writeReg (registered regfile write port),
// conflict_cnt (saturating count of contended IDLE cycles).
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    regfile_wb_arbiter_if.slave req,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              ctrl_writeEn,
    output logic [ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [1:0]        state;
    logic              inIdle;
    logic              inDone;
    logic              startClear;
    logic              arbBlock;
    logic              gnt0;
    logic              gnt1;
    logic              grantAny;
    logic [ADDR_W-1:0] grantReg;
    logic [DATA_W-1:0] grantData;
    logic              conflict;

    assign inIdle     = (state == S_IDLE);
    assign inDone     = (state == S_DONE);
    assign startClear = inIdle & clear_req;

    // Grants are allowed in IDLE and in the DONE cycle; a starting sweep
    // and reset both hold every requester off.
    assign arbBlock = ~ctrl_reset | ~(inIdle | inDone) | startClear;

    rr_arb2 uArb (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .valid0     (req.req0_valid),
        .valid1     (req.req1_valid),
        .block      (arbBlock),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign req.req0_ready = gnt0;
    assign req.req1_ready = gnt1;
    assign grantAny       = gnt0 | gnt1;

    always_comb begin
        grantReg  = req.req0_reg;
        grantData = req.req0_data;
        if (gnt1) begin
            grantReg  = req.req1_reg;
            grantData = req.req1_data;
        end
    end

    assign conflict = inIdle & req.req0_valid & req.req1_valid & ~clear_req;

    // During the sweep ctrl_writeReg doubles as the sweep index.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state         <= S_IDLE;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b0;
            ctrl_writeEn  <= 1'b0;
            ctrl_writeReg <= '0;
            data_writeReg <= '0;
        end else begin
            clear_done   <= 1'b0;
            ctrl_writeEn <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state         <= S_CLEAR;
                        clear_busy    <= 1'b1;
                        ctrl_writeEn  <= 1'b1;
                        ctrl_writeReg <= FIRST_IDX;
                        data_writeReg <= '0;
                    end
                end
                S_CLEAR: begin
                    if (ctrl_writeReg == LAST_IDX) begin
                        state      <= S_DONE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        ctrl_writeEn  <= 1'b1;
                        ctrl_writeReg <= ctrl_writeReg + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    clear_busy <= 1'b0;
                end
            endcase

            // Writes to r0 are accepted but never reach the regfile.
            if (grantAny && (grantReg != '0)) begin
                ctrl_writeEn  <= 1'b1;
                ctrl_writeReg <= grantReg;
                data_writeReg <= grantData;
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed table, sweep/reset corner
// sequences, regfile integration and a randomized run against a model.
module tb_regfile_wb_arbiter;
    import regfile_ctrl_pkg::*;

    localparam int CNT_W = 16;

    logic              clock = 1'b0;
    logic              ctrl_reset = 1'b0;
    logic              clear_req = 1'b0;
    logic              clear_busy;
    logic              clear_done;
    logic              ctrl_writeEn;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic [CNT_W-1:0]  conflict_cnt;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.CNT_W(CNT_W)) dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .req           (bus),
        .clear_req     (clear_req),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .ctrl_writeEn  (ctrl_writeEn),
        .ctrl_writeReg (ctrl_writeReg),
        .data_writeReg (data_writeReg),
        .conflict_cnt  (conflict_cnt)
    );

    always #5 clock = ~clock;

    // Behavioural regfile fed by the write port, two read ports.
    logic [31:0] rf [32];
    logic [4:0]  raddrA;
    logic [4:0]  raddrB;
    logic [31:0] rdataA;
    logic [31:0] rdataB;

    always @(posedge clock) begin
        if (ctrl_writeEn && ctrl_writeReg != 5'd0)
            rf[ctrl_writeReg] <= data_writeReg;
    end

    assign rdataA = (raddrA == 5'd0) ? 32'd0 : rf[raddrA];
    assign rdataB = (raddrB == 5'd0) ? 32'd0 : rf[raddrB];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0,
                         input logic [31:0] d0, input logic v1,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic clr);
        bus.req0_valid = v0;
        bus.req0_reg   = r0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_reg   = r1;
        bus.req1_data  = d1;
        clear_req      = clr;
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    // Inputs change at posedge+1, outputs are sampled at negedge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        er0;
        logic        er1;
        logic        een;
        logic [4:0]  ereg;
        logic [31:0] edat;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(logic v0, logic [4:0] r0, logic [31:0] d0,
                                logic v1, logic [4:0] r1, logic [31:0] d1,
                                logic er0, logic er1, logic een,
                                logic [4:0] ereg, logic [31:0] edat,
                                logic [15:0] ecnt);
        vec_t v;
        v.v0 = v0; v.r0 = r0; v.d0 = d0;
        v.v1 = v1; v.r1 = r1; v.d1 = d1;
        v.er0 = er0; v.er1 = er1; v.een = een;
        v.ereg = ereg; v.edat = edat; v.ecnt = ecnt;
        return v;
    endfunction

    // Randomized-run reference model state.
    int          cyc;
    int          clearT;
    bit          mPrio;
    bit          mEn;
    logic [4:0]  mReg;
    logic [31:0] mData;
    logic [15:0] mCnt;

    initial begin
        bit seenDone;
        bit sweeping;
        bit doneCyc;
        bit idleSt;
        bit blocked;
        bit er0;
        bit er1;
        int k;

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        raddrA = 5'd0;
        raddrB = 5'd0;

        // Reset with a request pending: everything must stay 0.
        drive(1'b1, 5'd5, 32'h0000DEAD, 1'b1, 5'd6, 32'h1, 1'b0);
        @(negedge clock);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_en", ctrl_writeEn, 0);
        chk("rst_reg", ctrl_writeReg, 0);
        chk("rst_data", data_writeReg, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        chk("rst_cnt", conflict_cnt, 0);
        next_cycle();
        ctrl_reset = 1'b1;

        // Single write, r0 suppression, contention.
        tbl[0] = mk(1, 5, 32'h0000DEAD, 0, 0, 0,
                    1, 0, 0, 0, 32'h0, 0);
        tbl[1] = mk(0, 0, 0, 1, 0, 32'hFFFFFFFF,
                    0, 1, 1, 5, 32'h0000DEAD, 0);
        tbl[2] = mk(1, 3, 32'h0000AAAA, 1, 4, 32'h0000BBBB,
                    1, 0, 0, 5, 32'h0000DEAD, 0);
        tbl[3] = mk(1, 3, 32'h0000AAAA, 1, 4, 32'h0000BBBB,
                    0, 1, 1, 3, 32'h0000AAAA, 1);
        tbl[4] = mk(1, 3, 32'h0000AAAA, 1, 4, 32'h0000BBBB,
                    1, 0, 1, 4, 32'h0000BBBB, 2);
        tbl[5] = mk(1, 3, 32'h0000AAAA, 1, 4, 32'h0000BBBB,
                    0, 1, 1, 3, 32'h0000AAAA, 3);
        tbl[6] = mk(0, 0, 0, 0, 0, 0,
                    0, 0, 1, 4, 32'h0000BBBB, 4);
        tbl[7] = mk(0, 0, 0, 0, 0, 0,
                    0, 0, 0, 4, 32'h0000BBBB, 4);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v0, tbl[i].r0, tbl[i].d0,
                  tbl[i].v1, tbl[i].r1, tbl[i].d1, 1'b0);
            @(negedge clock);
            chk($sformatf("tbl%0d_ready0", i), bus.req0_ready, tbl[i].er0);
            chk($sformatf("tbl%0d_ready1", i), bus.req1_ready, tbl[i].er1);
            chk($sformatf("tbl%0d_en", i), ctrl_writeEn, tbl[i].een);
            chk($sformatf("tbl%0d_reg", i), ctrl_writeReg, tbl[i].ereg);
            chk($sformatf("tbl%0d_data", i), data_writeReg, tbl[i].edat);
            chk($sformatf("tbl%0d_cnt", i), conflict_cnt, tbl[i].ecnt);
            next_cycle();
        end

        // Clear sweep with req0 pending; a second clear_req mid-sweep.
        drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clock);
        chk("clrT_ready0", bus.req0_ready, 0);
        chk("clrT_busy", clear_busy, 0);
        next_cycle();
        clear_req = 1'b0;
        for (int j = 1; j <= 31; j++) begin
            clear_req = (j == 5);
            @(negedge clock);
            chk($sformatf("sw%0d_ready0", j), bus.req0_ready, 0);
            chk($sformatf("sw%0d_en", j), ctrl_writeEn, 1);
            chk($sformatf("sw%0d_reg", j), ctrl_writeReg, j);
            chk($sformatf("sw%0d_data", j), data_writeReg, 0);
            chk($sformatf("sw%0d_busy", j), clear_busy, 1);
            chk($sformatf("sw%0d_done", j), clear_done, 0);
            next_cycle();
        end
        clear_req = 1'b0;
        @(negedge clock);
        chk("swdone_done", clear_done, 1);
        chk("swdone_en", ctrl_writeEn, 0);
        chk("swdone_busy", clear_busy, 0);
        chk("swdone_ready0", bus.req0_ready, 1);
        next_cycle();
        idle_in();
        @(negedge clock);
        chk("post_en", ctrl_writeEn, 1);
        chk("post_reg", ctrl_writeReg, 7);
        chk("post_data", data_writeReg, 32'h12345678);
        chk("post_done", clear_done, 0);
        next_cycle();

        // Reset while r10 is being written.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        next_cycle();
        clear_req = 1'b0;
        for (int j = 1; j < 10; j++) next_cycle();
        @(negedge clock);
        chk("mid_reg10", ctrl_writeReg, 10);
        #1 ctrl_reset = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        chk("mid_en", ctrl_writeEn, 0);
        chk("mid_reg", ctrl_writeReg, 0);
        chk("mid_busy", clear_busy, 0);
        chk("mid_ready0", bus.req0_ready, 0);
        chk("mid_cnt", conflict_cnt, 0);
        next_cycle();
        next_cycle();
        ctrl_reset = 1'b1;
        idle_in();
        seenDone = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            if (clear_done || clear_busy) seenDone = 1;
            next_cycle();
        end
        chk("mid_no_done", seenDone, 0);
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33, 1'b0);
        @(negedge clock);
        chk("mid_first_r0", bus.req0_ready, 1);
        chk("mid_first_r1", bus.req1_ready, 0);
        chk("mid_first_cnt", conflict_cnt, 0);
        next_cycle();
        idle_in();
        @(negedge clock);
        chk("mid_after_cnt", conflict_cnt, 1);
        chk("mid_after_reg", ctrl_writeReg, 2);
        next_cycle();

        // Integration: fill r1..r31 through both requesters, then clear.
        for (int r = 1; r <= 31; r++) begin
            if (r % 2 == 1)
                drive(1'b1, 5'(r), 32'h0000DEAD, 1'b0, 5'd0, 32'd0, 1'b0);
            else
                drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 32'h0000DEAD, 1'b0);
            next_cycle();
        end
        idle_in();
        next_cycle();
        next_cycle();
        raddrA = 5'd1;
        raddrB = 5'd30;
        #1;
        chk("int_fill_a", rdataA, 32'h0000DEAD);
        chk("int_fill_b", rdataB, 32'h0000DEAD);
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        seenDone = 0;
        for (int j = 0; j < 40 && !seenDone; j++) begin
            @(negedge clock);
            if (clear_done) seenDone = 1;
            next_cycle();
        end
        chk("int_done_seen", seenDone, 1);
        next_cycle();
        for (int i = 0; i < 32; i++) begin
            raddrA = 5'(i);
            raddrB = 5'(31 - i);
            #1;
            chk($sformatf("int_rdA%0d", i), rdataA, 0);
            chk($sformatf("int_rdB%0d", 31 - i), rdataB, 0);
        end

        // Randomized run against the model.
        ctrl_reset = 1'b0;
        idle_in();
        next_cycle();
        ctrl_reset = 1'b1;
        cyc = 0;
        clearT = -100;
        mPrio = 0;
        mEn = 0;
        mReg = 0;
        mData = 0;
        mCnt = 0;
        for (int n = 0; n < 500; n++) begin
            k = cyc - clearT;
            sweeping = (k >= 1 && k <= 31);
            doneCyc = (k == 32);
            idleSt = !sweeping && !doneCyc;
            drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
                  $urandom,
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
                  $urandom,
                  idleSt && ($urandom_range(0, 29) == 0));
            @(negedge clock);
            blocked = sweeping || (idleSt && clear_req);
            er0 = !blocked && bus.req0_valid && (!bus.req1_valid || !mPrio);
            er1 = !blocked && bus.req1_valid && (!bus.req0_valid || mPrio);
            chk("rnd_ready0", bus.req0_ready, er0);
            chk("rnd_ready1", bus.req1_ready, er1);
            chk("rnd_busy", clear_busy, sweeping);
            chk("rnd_done", clear_done, doneCyc);
            chk("rnd_cnt", conflict_cnt, mCnt);
            if (sweeping) begin
                chk("rnd_en", ctrl_writeEn, 1);
                chk("rnd_reg", ctrl_writeReg, k);
                chk("rnd_data", data_writeReg, 0);
                mReg = 5'(k);
                mData = 0;
            end else begin
                chk("rnd_en", ctrl_writeEn, mEn);
                chk("rnd_reg", ctrl_writeReg, mReg);
                chk("rnd_data", data_writeReg, mData);
            end
            if (idleSt && bus.req0_valid && bus.req1_valid && !clear_req
                && mCnt != 16'hFFFF)
                mCnt++;
            mEn = 0;
            if (er0) begin
                mPrio = 1;
                if (bus.req0_reg != 0) begin
                    mEn = 1;
                    mReg = bus.req0_reg;
                    mData = bus.req0_data;
                end
            end
            if (er1) begin
                mPrio = 0;
                if (bus.req1_reg != 0) begin
                    mEn = 1;
                    mReg = bus.req1_reg;
                    mData = bus.req1_data;
                end
            end
            if (idleSt && clear_req) clearT = cyc;
            cyc++;
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
